gpr_read_sched: RTL



---
 rtl/gpr_read_sched.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/gpr_read_sched.sv
// Bank-conflict read scheduler for the banked GPR file: collects one instruction's
// source operands over as many cycles as bank collisions require, one read per bank per cycle.
module gpr_read_sched #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned NUM_SRCS  = 3,
  parameter int unsigned NR_BITS   = 6,
  parameter int unsigned WIS_BITS  = 2,
  parameter int unsigned TAG_W     = 8,
  parameter int unsigned PERF_W    = 44,
  localparam int unsigned BANK_SEL_BITS = $clog2(NUM_BANKS),
  localparam int unsigned SRC_SEL_W     = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1,
  localparam int unsigned WIS_W         = (WIS_BITS > 0) ? WIS_BITS : 1,
  localparam int unsigned AW            = NR_BITS - BANK_SEL_BITS + WIS_BITS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [NUM_SRCS*NR_BITS-1:0]    req_rs,
  input  logic [WIS_W-1:0]               req_wis,
  input  logic [TAG_W-1:0]               req_tag,
  output logic [NUM_BANKS-1:0]           bank_rd_en,
  output logic [NUM_BANKS*AW-1:0]        bank_rd_addr,
  output logic [NUM_BANKS*SRC_SEL_W-1:0] bank_rd_src,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [TAG_W-1:0]               rsp_tag,
  output logic [PERF_W-1:0]              perf_conflicts
);

  localparam int unsigned BSB_W = (BANK_SEL_BITS > 0) ? BANK_SEL_BITS : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [NUM_SRCS-1:0]         pend_q, pend_d;
  logic [NUM_SRCS*NR_BITS-1:0] rs_q, rs_d;
  logic [WIS_W-1:0]            wis_q, wis_d;
  logic [TAG_W-1:0]            tag_q, tag_d;
  logic [PERF_W-1:0]           perf_q, perf_d;

  logic [NUM_SRCS-1:0] grant;
  logic [NUM_SRCS-1:0] pend_new;
  logic [NUM_SRCS-1:0] pend_left;
  logic                accept;

  function automatic logic [BSB_W-1:0] bank_of(input logic [NR_BITS-1:0] rs);
    if (BANK_SEL_BITS == 0) bank_of = '0;
    else                    bank_of = rs[BSB_W-1:0];
  endfunction

  // Row address inside a bank, with the warp index appended below it.
  function automatic logic [AW-1:0] slot_addr(input logic [NR_BITS-1:0] rs,
                                              input logic [WIS_W-1:0]   wis);
    logic [NR_BITS-1:0] row;
    row = rs >> BANK_SEL_BITS;
    if (WIS_BITS == 0) slot_addr = AW'(row);
    else               slot_addr = AW'({row, wis});
  endfunction

  assign req_ready      = (state_q == S_IDLE) || ((state_q == S_DONE) && rsp_ready);
  assign accept         = req_valid && req_ready;
  assign rsp_valid      = (state_q == S_DONE);
  assign rsp_tag        = tag_q;
  assign perf_conflicts = perf_q;

  // Per-bank grant: lowest-index pending slot mapped to that bank wins.
  always_comb begin
    grant        = '0;
    bank_rd_en   = '0;
    bank_rd_addr = '0;
    bank_rd_src  = '0;
    if (state_q == S_READ) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        for (int unsigned i = 0; i < NUM_SRCS; i++) begin
          if (!bank_rd_en[b] && pend_q[i] &&
              (bank_of(rs_q[i*NR_BITS +: NR_BITS]) == BSB_W'(b))) begin
            bank_rd_en[b]                         = 1'b1;
            grant[i]                              = 1'b1;
            bank_rd_addr[b*AW +: AW]              = slot_addr(rs_q[i*NR_BITS +: NR_BITS], wis_q);
            bank_rd_src[b*SRC_SEL_W +: SRC_SEL_W] = SRC_SEL_W'(i);
          end
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    rs_d      = rs_q;
    wis_d     = wis_q;
    tag_d     = tag_q;
    perf_d    = perf_q;
    pend_new  = '0;
    for (int unsigned i = 0; i < NUM_SRCS; i++) begin
      pend_new[i] = |req_rs[i*NR_BITS +: NR_BITS];
    end
    pend_left = pend_q & ~grant;

    case (state_q)
      S_IDLE: ;
      S_READ: begin
        pend_d = pend_left;
        if (pend_left == '0) state_d = S_DONE;
        else                 perf_d  = perf_q + PERF_W'(1);
      end
      S_DONE: begin
        if (rsp_ready && !req_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Accept is only possible from IDLE or a consumed DONE; x0 slots never read.
    if (accept) begin
      rs_d    = req_rs;
      wis_d   = req_wis;
      tag_d   = req_tag;
      pend_d  = pend_new;
      state_d = (pend_new != '0) ? S_READ : S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      rs_q    <= '0;
      wis_q   <= '0;
      tag_q   <= '0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      rs_q    <= rs_d;
      wis_q   <= wis_d;
      tag_q   <= tag_d;
      perf_q  <= perf_d;
    end
  end

endmodule
